cv32e40p_instr_obi_arbiter: RTL

CV32E40P_INSTR_OBI_ARBITER -- requirements
Module: cv32e40p_instr_obi_arbiter

---
 rtl/cv32e40p_instr_obi_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/cv32e40p_instr_obi_arbiter.sv
// Two-port OBI instruction arbiter (fetch F, auxiliary A) with in-order response routing.
// Define CV32E40P_INSTR_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority F over A.
module cv32e40p_instr_obi_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        fetch_req_i,
    input  logic [31:0] fetch_addr_i,
    output logic        fetch_gnt_o,
    output logic        fetch_rvalid_o,
    output logic [31:0] fetch_rdata_o,
    output logic        fetch_err_o,

    input  logic        aux_req_i,
    input  logic [31:0] aux_addr_i,
    output logic        aux_gnt_o,
    output logic        aux_rvalid_o,
    output logic [31:0] aux_rdata_o,
    output logic        aux_err_o,

    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,

    output logic        busy_o
);

    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] PTR_MAX = PW'(MAX_OUTSTANDING - 1);

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_e;

    state_e r_state;
    state_e w_state_nxt;

    // Port IDs: 0 = fetch, 1 = aux
    logic          r_sel;
    logic          r_ids [MAX_OUTSTANDING];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;

    logic w_pick;
    logic w_sel;
    logic w_full;
    logic w_req;
    logic w_push;
    logic w_pop;
    logic w_head;

`ifdef CV32E40P_INSTR_ARB_ROUND_ROBIN_EN
    logic r_last;

    assign w_pick = fetch_req_i ? (aux_req_i & ~r_last) : aux_req_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_push) begin
            r_last <= w_sel;
        end
    end
`else
    assign w_pick = ~fetch_req_i & aux_req_i;
`endif

    // Full is taken from the registered count only, so rvalid never reaches req
    assign w_full = (r_cnt == CNT_MAX);
    assign w_sel  = (r_state == S_LOCKED) ? r_sel : w_pick;
    assign w_req  = ~w_full & (w_sel ? aux_req_i : fetch_req_i);
    assign w_push = w_req & instr_gnt_i;
    assign w_pop  = instr_rvalid_i & (r_cnt != '0);
    assign w_head = r_ids[r_rptr];

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_req && !instr_gnt_i) begin
                    w_state_nxt = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (!w_req || instr_gnt_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sel   <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_req) begin
                r_sel <= w_sel;
            end
            if (w_push) begin
                r_wptr <= (r_wptr == PTR_MAX) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PTR_MAX) ? '0 : r_rptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ids[r_wptr] <= w_sel;
        end
    end

    assign instr_req_o  = w_req;
    assign instr_addr_o = w_req ? (w_sel ? aux_addr_i : fetch_addr_i) : '0;

    assign fetch_gnt_o  = w_push & ~w_sel;
    assign aux_gnt_o    = w_push & w_sel;

    assign fetch_rvalid_o = w_pop & ~w_head;
    assign aux_rvalid_o   = w_pop & w_head;
    assign fetch_rdata_o  = fetch_rvalid_o ? instr_rdata_i : '0;
    assign aux_rdata_o    = aux_rvalid_o ? instr_rdata_i : '0;
    assign fetch_err_o    = fetch_rvalid_o & instr_err_i;
    assign aux_err_o      = aux_rvalid_o & instr_err_i;

    assign busy_o = (r_cnt != '0) | w_req;

endmodule
